ps2_scancode_decoder: RTL



---
 rtl/ps2_scancode_decoder_pkg.sv | 38 +++
 rtl/ps2_scancode_decoder_if.sv | 22 ++
 rtl/ps2_scancode_decoder_seq_timeout.sv | 41 ++++
 rtl/ps2_scancode_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared definitions for the PS/2 Set-2 scancode decoder: FSM state type,
// protocol byte constants and the controller-response classifier.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0,
      SKIP_PAUSE
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BRK        = 8'hF0;
   localparam logic [7:0] PS2_PAUSE      = 8'hE1;
   localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
   localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

   localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
   localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RSP_BAT_NG = 8'hFC;
   localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
   localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

   // Pause sends E1 followed by seven more bytes that carry no key information.
   localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

   // Bytes the keyboard sends as command responses rather than scancodes.
   function automatic logic is_response(input logic [7:0] b);
      return (b == PS2_RSP_ERR0)   || (b == PS2_RSP_BAT_OK) ||
             (b == PS2_RSP_ACK)    || (b == PS2_RSP_ECHO)   ||
             (b == PS2_RSP_BAT_NG) || (b == PS2_RSP_RESEND) ||
             (b == PS2_RSP_ERR1);
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte stream in from PS2_Controller and decoded key events out.
// The decoder uses the slave modport; the byte source uses master.
interface ps2_scancode_decoder_if;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       key_event;
   logic [7:0] key_code;
   logic       key_extended;
   logic       key_released;
   logic [3:0] key_held;
   logic       seq_error;

   modport master (
      output received_data, received_data_en,
      input  key_event, key_code, key_extended, key_released, key_held, seq_error
   );

   modport slave (
      input  received_data, received_data_en,
      output key_event, key_code, key_extended, key_released, key_held, seq_error
   );
endinterface

// File: rtl/ps2_scancode_decoder_seq_timeout.sv
// Inter-byte timeout for multi-byte PS/2 sequences. The count restarts on
// clear, advances while enabled and raises expire on the last allowed cycle;
// a clear on that same cycle suppresses expire so a late byte still counts.
module ps2_seq_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count and expiry detect.
   always_comb begin
      cnt_d  = '0;
      expire = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = cnt_q;
            expire = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: folds E0/F0/E1 sequences into single key
// events and tracks held state for four configurable keys.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated identical makes.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  TRACK0_CODE    = 8'h29,
   parameter logic [7:0]  TRACK1_CODE    = 8'h5A,
   parameter logic [7:0]  TRACK2_CODE    = 8'h1C,
   parameter logic [7:0]  TRACK3_CODE    = 8'h1B
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   ps2_scancode_decoder_if.slave  bus
);

   localparam logic [7:0] TRACK_CODES [4] = '{TRACK0_CODE, TRACK1_CODE, TRACK2_CODE, TRACK3_CODE};

   ps2_state_e state_q, state_d;
   logic [2:0] skip_q, skip_d;

   logic       ev_fire;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_rel;
   logic       err;
   logic       emit;
   logic       expire;

   logic       key_event_q, key_event_d;
   logic [7:0] key_code_q, key_code_d;
   logic       key_extended_q, key_extended_d;
   logic       key_released_q, key_released_d;
   logic [3:0] key_held_q, key_held_d;
   logic       seq_error_q, seq_error_d;

   ps2_seq_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (CLOCK_50),
      .rst    (reset),
      .clear  (bus.received_data_en),
      .enable (state_q != IDLE),
      .expire (expire)
   );

   // Sequence FSM: next state and the decoded event for this byte.
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      ev_fire = 1'b0;
      ev_code = bus.received_data;
      ev_ext  = 1'b0;
      ev_rel  = 1'b0;
      err     = 1'b0;
      if (bus.received_data_en) begin
         unique case (state_q)
            IDLE: begin
               if (bus.received_data == PS2_EXT) begin
                  state_d = GOT_E0;
               end else if (bus.received_data == PS2_BRK) begin
                  state_d = GOT_F0;
               end else if (bus.received_data == PS2_PAUSE) begin
                  state_d = SKIP_PAUSE;
                  skip_d  = PAUSE_SKIP_LEN;
               end else if (!is_response(bus.received_data)) begin
                  ev_fire = 1'b1;
               end
            end
            GOT_E0: begin
               if (bus.received_data == PS2_BRK) begin
                  state_d = GOT_E0F0;
               end else if (bus.received_data == PS2_EXT) begin
                  state_d = GOT_E0;
               end else if (bus.received_data == PS2_FAKE_SHIFT) begin
                  state_d = IDLE;
               end else begin
                  ev_fire = 1'b1;
                  ev_ext  = 1'b1;
                  state_d = IDLE;
               end
            end
            GOT_F0: begin
               state_d = IDLE;
               if (bus.received_data == PS2_EXT || bus.received_data == PS2_BRK) begin
                  err = 1'b1;
               end else begin
                  ev_fire = 1'b1;
                  ev_rel  = 1'b1;
               end
            end
            GOT_E0F0: begin
               state_d = IDLE;
               if (bus.received_data != PS2_FAKE_SHIFT) begin
                  ev_fire = 1'b1;
                  ev_ext  = 1'b1;
                  ev_rel  = 1'b1;
               end
            end
            SKIP_PAUSE: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  ev_fire = 1'b1;
                  ev_code = PS2_PAUSE_CODE;
                  ev_ext  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (expire) begin
         err     = 1'b1;
         state_d = IDLE;
      end
   end

   // FSM state and pause skip counter.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         skip_q  <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [7:0] last_code_q, last_code_d;
   logic       last_ext_q, last_ext_d;
   logic       last_valid_q, last_valid_d;
   logic       same_as_last;

   // Auto-repeat filter: drop a make identical to the last remembered make.
   always_comb begin
      last_code_d  = last_code_q;
      last_ext_d   = last_ext_q;
      last_valid_d = last_valid_q;
      emit         = ev_fire;
      same_as_last = last_valid_q && (last_code_q == ev_code) && (last_ext_q == ev_ext);
      if (ev_fire) begin
         if (!ev_rel) begin
            if (same_as_last) begin
               emit = 1'b0;
            end else begin
               last_code_d  = ev_code;
               last_ext_d   = ev_ext;
               last_valid_d = 1'b1;
            end
         end else if (same_as_last) begin
            last_valid_d = 1'b0;
         end
      end
   end

   // Last-make memory.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         last_code_q  <= '0;
         last_ext_q   <= 1'b0;
         last_valid_q <= 1'b0;
      end else begin
         last_code_q  <= last_code_d;
         last_ext_q   <= last_ext_d;
         last_valid_q <= last_valid_d;
      end
   end
`else
   // Every decoded event is presented.
   always_comb begin
      emit = ev_fire;
   end
`endif

   // Output next-values: event fields hold between events, held flags follow
   // non-extended make/break of the tracked codes even when a make is filtered.
   always_comb begin
      key_event_d    = emit;
      key_code_d     = key_code_q;
      key_extended_d = key_extended_q;
      key_released_d = key_released_q;
      key_held_d     = key_held_q;
      seq_error_d    = err;
      if (emit) begin
         key_code_d     = ev_code;
         key_extended_d = ev_ext;
         key_released_d = ev_rel;
      end
      if (ev_fire && !ev_ext) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (ev_code == TRACK_CODES[i]) key_held_d[i] = !ev_rel;
         end
      end
   end

   // Output registers.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         key_event_q    <= 1'b0;
         key_code_q     <= '0;
         key_extended_q <= 1'b0;
         key_released_q <= 1'b0;
         key_held_q     <= '0;
         seq_error_q    <= 1'b0;
      end else begin
         key_event_q    <= key_event_d;
         key_code_q     <= key_code_d;
         key_extended_q <= key_extended_d;
         key_released_q <= key_released_d;
         key_held_q     <= key_held_d;
         seq_error_q    <= seq_error_d;
      end
   end

   assign bus.key_event    = key_event_q;
   assign bus.key_code     = key_code_q;
   assign bus.key_extended = key_extended_q;
   assign bus.key_released = key_released_q;
   assign bus.key_held     = key_held_q;
   assign bus.seq_error    = seq_error_q;

endmodule
